// File: rtl/sisc_mem_pkg.sv
// Shared types and constants for the SISC memory arbiter.
package sisc_mem_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  // Requester identity latched at arbitration.
  typedef logic req_id_t;

  localparam req_id_t REQ_IF = 1'b0;
  localparam req_id_t REQ_DM = 1'b1;

  // Default memory read latency in cycles.
  localparam int unsigned MEM_LAT_DEF = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory arbiter.
// MEM_ARB_FAIR_EN: fetch wins once the data-grant streak reaches STARVE_MAX.
module mem_arb_pick
  import sisc_mem_pkg::*;
`ifdef MEM_ARB_FAIR_EN
#(
  parameter int unsigned SC_W       = 3,
  parameter int unsigned STARVE_MAX = 4
)
`endif
(
  input  logic            if_req,
  input  logic            dm_req,
`ifdef MEM_ARB_FAIR_EN
  input  logic [SC_W-1:0] starve_cnt,
`endif
  output req_id_t         pick_c
);

  // Data has priority; fetch wins only when it is the sole requester or is starved.
  always_comb begin
    pick_c = (if_req && !dm_req) ? REQ_IF : REQ_DM;
`ifdef MEM_ARB_FAIR_EN
    if (if_req && (starve_cnt == SC_W'(STARVE_MAX))) begin
      pick_c = REQ_IF;
    end
`endif
  end

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter: fetch vs. load/store, one transaction in flight.
// Optional fairness build: define MEM_ARB_FAIR_EN.
module mem_arb
  import sisc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned STARVE_MAX = 4
)(
  input  logic              clk,
  input  logic              rst_f,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  lat_q, lat_d;
  req_id_t           win_q, win_d, pick_c;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, dm_rdata_d;
  logic              if_gnt_d, dm_gnt_d, if_rvalid_d, dm_rvalid_d;
  logic              mem_en_d, mem_we_d, busy_d;
  logic              arb_c, any_req_c;

  assign arb_c     = (state_q == IDLE) || (state_q == RESP);
  assign any_req_c = if_req || dm_req;

`ifdef MEM_ARB_FAIR_EN
  localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);

  logic [SC_W-1:0] starve_q, starve_d;

  mem_arb_pick #(
    .SC_W       (SC_W),
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .starve_cnt (starve_q),
    .pick_c     (pick_c)
  );

  // Streak of data grants made while fetch was waiting.
  always_comb begin
    starve_d = starve_q;
    if (arb_c) begin
      if (!if_req || (pick_c == REQ_IF)) begin
        starve_d = '0;
      end else begin
        starve_d = starve_q + SC_W'(1);
      end
    end
  end
`else
  mem_arb_pick u_pick (
    .if_req (if_req),
    .dm_req (dm_req),
    .pick_c (pick_c)
  );

  // STARVE_MAX only matters in the fairness build; kept so both builds share one parameter list.
  if (STARVE_MAX == 0) begin : g_starve_max_unused
  end
`endif

  // Next state, latched request and next registered outputs.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    win_d       = win_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        if (any_req_c) begin
          state_d  = ACCESS;
          win_d    = pick_c;
          mem_en_d = 1'b1;
          if (pick_c == REQ_DM) begin
            we_d        = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            mem_we_d    = dm_we;
            dm_gnt_d    = 1'b1;
          end else begin
            we_d        = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            if_gnt_d    = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = WAIT;
        lat_d   = CNT_W'(MEM_LAT - 1);
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = RESP;
          if (win_q == REQ_IF) begin
            if_rdata_d  = mem_rdata;
            if_rvalid_d = 1'b1;
          end else begin
            dm_rdata_d  = we_q ? '0 : mem_rdata;
            dm_rvalid_d = 1'b1;
          end
        end else begin
          lat_d = lat_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      win_q     <= REQ_IF;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
      starve_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      win_q     <= win_d;
      we_q      <= we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
      if_gnt    <= if_gnt_d;
      dm_gnt    <= dm_gnt_d;
      if_rvalid <= if_rvalid_d;
      dm_rvalid <= dm_rvalid_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      busy      <= busy_d;
`ifdef MEM_ARB_FAIR_EN
      starve_q  <= starve_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: one instance at MEM_LAT=2, one at MEM_LAT=1.
module tb_mem_arb;
  import sisc_mem_pkg::*;

  localparam logic [31:0] JUNK = 32'h5A5A_5A5A;

  logic clk;
  logic rst_f;

  // Instance A (MEM_LAT=2)
  logic        if_req, if_gnt, if_rvalid;
  logic [15:0] if_addr;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  // Instance B (MEM_LAT=1)
  logic        b_if_req, b_if_gnt, b_if_rvalid;
  logic [15:0] b_if_addr;
  logic [31:0] b_if_rdata;
  logic        b_dm_req, b_dm_we, b_dm_gnt, b_dm_rvalid;
  logic [15:0] b_dm_addr;
  logic [31:0] b_dm_wdata, b_dm_rdata;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [15:0] b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_arb #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut_a (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arb #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_b (
    .clk(clk), .rst_f(rst_f),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Fixed-latency memory models; read data is JUNK outside its valid cycle.
  logic [31:0] mem_a [0:255] = '{4: 32'h1023_0000, default: 32'h0};
  logic [31:0] mem_b [0:255] = '{8: 32'hCAFE_0001, default: 32'h0};
  logic [31:0] pipe_a0, pipe_a1, pipe_b0;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem_a[mem_addr[7:0]] <= mem_wdata;
    pipe_a0 <= mem_en ? mem_a[mem_addr[7:0]] : JUNK;
    pipe_a1 <= pipe_a0;
  end
  assign mem_rdata = pipe_a1;

  always @(posedge clk) begin
    if (b_mem_en && b_mem_we) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
    pipe_b0 <= b_mem_en ? mem_b[b_mem_addr[7:0]] : JUNK;
  end
  assign b_mem_rdata = pipe_b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  req_id_t gseq [0:9];
  int      gcyc [0:9];
  int      n;
  logic    seen;

  initial begin
    rst_f = 1'b1;
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    b_if_req = 0; b_if_addr = '0; b_dm_req = 0; b_dm_we = 0; b_dm_addr = '0; b_dm_wdata = '0;
    step(); step();

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt", {30'd0, if_gnt, dm_gnt}, 0);
    chk("rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 0);
    chk("rst_mem", {29'd0, mem_en, mem_we, 1'b0} | 32'(mem_addr) | mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_b", {28'd0, b_busy, b_dm_gnt, b_dm_rvalid, 1'b0} | b_dm_rdata, 0);
    rst_f = 1'b0;
    step();

    // Fetch read at MEM_LAT=2
    if_req = 1; if_addr = 16'h0004;
    step();
    chk("f_if_gnt", 32'(if_gnt), 1);
    chk("f_mem_en", 32'(mem_en), 1);
    chk("f_mem_addr", 32'(mem_addr), 32'h0004);
    chk("f_mem_we", 32'(mem_we), 0);
    chk("f_busy", 32'(busy), 1);
    if_req = 0;
    step(); chk("f_rv_c2", 32'(if_rvalid), 0);
    step(); chk("f_rv_c3", 32'(if_rvalid), 0);
    step();
    chk("f_rv_c4", 32'(if_rvalid), 1);
    chk("f_rdata", if_rdata, 32'h1023_0000);
    step();
    chk("f_rv_c5", 32'(if_rvalid), 0);
    chk("f_idle", 32'(busy), 0);

    // Store to 0x0010
    dm_req = 1; dm_we = 1; dm_addr = 16'h0010; dm_wdata = 32'hDEAD_BEEF;
    step();
    chk("s_dm_gnt", 32'(dm_gnt), 1);
    chk("s_mem_we", 32'(mem_we), 1);
    chk("s_mem_addr", 32'(mem_addr), 32'h0010);
    chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    dm_req = 0; dm_we = 0;
    step(); step(); step();
    chk("s_rvalid", 32'(dm_rvalid), 1);
    chk("s_rdata", dm_rdata, 0);
    chk("s_if_hold", if_rdata, 32'h1023_0000);
    step();

    // Load back from 0x0010
    dm_req = 1; dm_we = 0; dm_addr = 16'h0010;
    step();
    chk("l_dm_gnt", 32'(dm_gnt), 1);
    chk("l_mem_we", 32'(mem_we), 0);
    dm_req = 0;
    step(); step(); step();
    chk("l_rvalid", 32'(dm_rvalid), 1);
    chk("l_rdata", dm_rdata, 32'hDEAD_BEEF);
    step();

    // Both requesting: data first, fetch follows RESP->ACCESS
    if_req = 1; if_addr = 16'h0004; dm_req = 1; dm_we = 0; dm_addr = 16'h0010;
    step();
    chk("b_dm_gnt1", {30'd0, if_gnt, dm_gnt}, 32'b01);
    dm_req = 0;
    step(); step(); step();
    chk("b_dm_rv4", {30'd0, if_gnt, dm_rvalid}, 32'b01);
    step();
    chk("b_if_gnt5", {30'd0, if_gnt, dm_gnt}, 32'b10);
    chk("b_addr5", 32'(mem_addr), 32'h0004);
    chk("b_busy5", 32'(busy), 1);
    if_req = 0;
    step(); step();
    chk("b_if_rv7", 32'(if_rvalid), 0);
    step();
    chk("b_if_rv8", {30'd0, if_rvalid, if_gnt}, 32'b10);
    chk("b_if_rdata8", if_rdata, 32'h1023_0000);
    chk("b_dm_hold8", dm_rdata, 32'hDEAD_BEEF);
    step();

    // Both held continuously: grant order and back-to-back spacing
    if_req = 1; if_addr = 16'h0004; dm_req = 1; dm_we = 0; dm_addr = 16'h0010;
    n = 0;
    for (int c = 1; c <= 100 && n < 10; c++) begin
      step();
      if (dm_gnt && n < 10) begin gseq[n] = REQ_DM; gcyc[n] = c; n++; end
      if (if_gnt && n < 10) begin gseq[n] = REQ_IF; gcyc[n] = c; n++; end
    end
    if_req = 0; dm_req = 0;
    chk("h_ngrants", 32'(n), 10);
    for (int i = 0; i < n; i++) begin
`ifdef MEM_ARB_FAIR_EN
      chk($sformatf("h_grant%0d", i), 32'(gseq[i]), (i % 5 == 4) ? 32'(REQ_IF) : 32'(REQ_DM));
`else
      chk($sformatf("h_grant%0d", i), 32'(gseq[i]), 32'(REQ_DM));
`endif
      if (i > 0) chk($sformatf("h_gap%0d", i), 32'(gcyc[i] - gcyc[i-1]), 4);
    end
    for (int c = 0; c < 20 && busy; c++) step();
    chk("h_drain", 32'(busy), 0);
    step();

    // Reset during WAIT of a load: transaction dropped
    dm_req = 1; dm_we = 0; dm_addr = 16'h0010;
    step();
    chk("r_dm_gnt", 32'(dm_gnt), 1);
    dm_req = 0;
    step();
    rst_f = 1;
    step();
    rst_f = 0;
    chk("r_busy", 32'(busy), 0);
    chk("r_rdata", dm_rdata | if_rdata, 0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (dm_rvalid) seen = 1'b1;
      step();
    end
    chk("r_no_rvalid", 32'(seen), 0);
    dm_req = 1;
    step();
    chk("r2_dm_gnt", 32'(dm_gnt), 1);
    dm_req = 0;
    step(); step(); step();
    chk("r2_rvalid", 32'(dm_rvalid), 1);
    chk("r2_rdata", dm_rdata, 32'hDEAD_BEEF);
    step();

    // MEM_LAT=1 fetch
    b_if_req = 1; b_if_addr = 16'h0008;
    step();
    chk("m1_gnt", {30'd0, b_if_gnt, b_mem_en}, 32'b11);
    chk("m1_addr", 32'(b_mem_addr), 32'h0008);
    chk("m1_we", 32'(b_mem_we), 0);
    b_if_req = 0;
    step();
    chk("m1_rv2", 32'(b_if_rvalid), 0);
    step();
    chk("m1_rv3", 32'(b_if_rvalid), 1);
    chk("m1_rdata", b_if_rdata, 32'hCAFE_0001);
    step();
    chk("m1_idle", {30'd0, b_busy, b_if_rvalid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Single-port memory arbiter for the SISC processor. Shares one memory array between the instruction-fetch requester (PC/IR path) and the load/store requester (data path). It sequences each access through a fixed-latency memory and returns read data or a write acknowledgement to the requester that was granted. One transaction is in flight at a time; data accesses take priority over fetch, with an optional anti-starvation rule.

## Interface
- `ADDR_W`, 16, address width (matches PC width)
- `DATA_W`, 32, data/instruction width
- `MEM_LAT`, 2, cycles from the `mem_en` cycle to `mem_rdata` valid; legal values ≥1
- `STARVE_MAX`, 4, consecutive data grants tolerated while fetch waits (only with the fairness macro)

Ports:
- `clk`  in  1  clock; all logic on its rising edge
- `rst_f`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request; held high until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req` is high
- `if_gnt`  out  1  one-cycle pulse: fetch accepted
- `if_rvalid`  out  1  one-cycle pulse: `if_rdata` valid
- `if_rdata`  out  DATA_W  fetched instruction
- `dm_req`, `dm_we`  in  1  data request and write enable; held until `dm_gnt`
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_gnt`  out  1  one-cycle pulse: data access accepted
- `dm_rvalid`  out  1  one-cycle pulse: load data valid, or store complete
- `dm_rdata`  out  DATA_W  load data; 0 on store completion
- `mem_en`, `mem_we`  out  1  memory access strobe and write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  high in every state except IDLE

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- In IDLE and RESP, requests are sampled. If any request is high, the next state is ACCESS with the winner latched. Otherwise the next state is IDLE.
- ACCESS lasts one cycle:
  - `mem_en`=1; `mem_addr`, `mem_we` and `mem_wdata` come from registers latched at arbitration.
  - The winner's `gnt` pulses.
  - Fetch always drives `mem_we`=0.
- WAIT lasts exactly MEM_LAT cycles, using a down-counter loaded with MEM_LAT-1. On its last cycle `mem_rdata` is captured (reads only).
- RESP lasts one cycle. The winner's `rvalid` pulses with the registered data. The other requester's `rdata` holds its last value.
- Priority: if `dm_req` and `if_req` are both high, data wins.
- A requester that keeps `req` high after `gnt` is treated as issuing a new request. Back-to-back transactions therefore run RESP→ACCESS with no IDLE cycle.
- Reset, including mid-transaction:
  - The state returns to IDLE and the in-flight transaction is dropped; no `rvalid` is ever emitted for it.
  - All outputs, including both `rdata` buses, are 0.
  - The starvation counter is cleared.

## Timing
- Request sampled in cycle 0 (IDLE) → `gnt` and `mem_en` in cycle 1 → `rvalid` in cycle 2+MEM_LAT.
- Back-to-back throughput: one transaction per MEM_LAT+2 cycles.
- `gnt` and `rvalid` are never high in the same cycle. At most one `gnt` and one `rvalid` are high in any cycle.
- With MEM_LAT=1, WAIT is a single cycle and `rvalid` falls in cycle 3.

## Configuration
- `MEM_ARB_FAIR_EN` defined:
  - A counter tracks consecutive data grants made while `if_req` is high.
  - When the counter equals STARVE_MAX, the next arbitration with `if_req` high grants fetch, even if `dm_req` is high.
  - The counter clears on any fetch grant, and in any arbitration cycle where `if_req` is low.
- `MEM_ARB_FAIR_EN` undefined: strict data priority, no counter logic.

## Structure
- Shared package `sisc_mem_pkg` holds:
  - the state enum (IDLE/ACCESS/WAIT/RESP);
  - the requester ID constants (`REQ_IF`, `REQ_DM`);
  - default MEM_LAT.
- Sub-module `mem_arb_pick`: combinational winner select with the fairness override, under the macro. The FSM, latency counter and response registers stay in `mem_arb`.

## Test plan
- Fetch read, MEM_LAT=2, `if_req`@cycle0, `if_addr`=0x0004, memory word 0x10230000 → `if_gnt`@1, `mem_en`@1 with `mem_addr`=0x0004, `if_rvalid`@4 with `if_rdata`=0x10230000.
- Store: `dm_req`=1, `dm_we`=1, `dm_addr`=0x0010, `dm_wdata`=0xDEADBEEF → `mem_we`=1 @1, `dm_rvalid`@4 with `dm_rdata`=0; a later load from 0x0010 returns 0xDEADBEEF.
- Both requests high @0 → `dm_gnt`@1; fetch held → `if_gnt`@5 (RESP→ACCESS); `if_rvalid`@8.
- `MEM_ARB_FAIR_EN`, STARVE_MAX=4, `dm_req` and `if_req` held continuously → 4 data grants, then 1 fetch grant, repeating.
- `rst_f` pulsed in the WAIT cycle of a load → next cycle IDLE, `busy`=0, no `dm_rvalid` ever for that load; a new request afterwards completes normally.
- MEM_LAT=1, single fetch @0 → `if_gnt`@1, `if_rvalid`@3.
